input_conditioner: RTL



---
 rtl/input_conditioner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Conditions the raw DE2 keys and switches for slc3.
// Keys are synchronized, inverted to active-high, debounced, and turned into levels and press pulses.

module input_conditioner_key #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_pulse
);
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Entering a WAIT state takes one edge, so the counter needs one fewer count.
    // After that, DEBOUNCE_CYCLES stable synchronized samples have been seen.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             r_meta;
    logic             r_sync;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pulse;
    logic             w_pulse_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= ~i_key_n;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_pulse_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_pulse_next = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_sync) w_state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!r_sync) begin
                    w_state_next = RELEASED;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_next = PRESSED;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!r_sync) w_state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (r_sync) begin
                    w_state_next = PRESSED;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_next = RELEASED;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = RELEASED;
        endcase
    end

    assign o_level = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign o_pulse = r_pulse;
endmodule

module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] Switches_raw,
    output logic        Run_level,
    output logic        Continue_level,
    output logic        Run_pulse,
    output logic        Continue_pulse,
    output logic [15:0] Switches
);
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;

    input_conditioner_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_run (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_key_n(Run),
        .o_level(Run_level),
        .o_pulse(Run_pulse)
    );

    input_conditioner_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_continue (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_key_n(Continue),
        .o_level(Continue_level),
        .o_pulse(Continue_pulse)
    );

    // Switches are static operator settings, so they are synchronized but not debounced.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= Switches_raw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign Switches = r_sw_sync;
endmodule
